// File: rtl/dbg_pkg.sv
// Shared encodings for the system-bus-access AHB master: AHB HTRANS/HRESP
// values, sberror codes and the transfer FSM state encoding.
// No logic; imported by the interface consumers and the datapath.
package dbg_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    localparam logic [2:0] SBERR_NONE    = 3'd0;
    localparam logic [2:0] SBERR_TIMEOUT = 3'd1;
    localparam logic [2:0] SBERR_BUS     = 3'd2;
    localparam logic [2:0] SBERR_ALIGN   = 3'd3;
    localparam logic [2:0] SBERR_SIZE    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ADDR = 2'd2,
        ST_DATA = 2'd3
    } sba_state_e;

endpackage

// File: rtl/sba_ahb_master_if.sv
// AHB master-side bus bundle: grant/ready/response/read data towards the
// master, request/address/control/write data towards the slave side.
// master modport is used by sba_ahb_master; slave modport by a bus model.
interface sba_ahb_master_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    logic              HGRANT;
    logic              HREADY;
    logic [1:0]        HRESP;
    logic [DATA_W-1:0] HRDATA;
    logic              HBUSREQ;
    logic [1:0]        HTRANS;
    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;

    modport master (
        input  HGRANT, HREADY, HRESP, HRDATA,
        output HBUSREQ, HTRANS, HADDR, HWRITE, HSIZE, HWDATA, HBURST, HPROT
    );

    modport slave (
        output HGRANT, HREADY, HRESP, HRDATA,
        input  HBUSREQ, HTRANS, HADDR, HWRITE, HSIZE, HWDATA, HBURST, HPROT
    );
endinterface

// File: rtl/sba_lane_align.sv
// Byte-lane alignment: extracts the addressed lane of AHB read data
// (right-justified, zero-extended) and replicates write data over all lanes.
// Purely combinational, zero latency, no flow control.
// Ports: lane (low address bits), access (log2 bytes), bus_rdata/rdata, wdata/bus_wdata.
module sba_lane_align #(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] lane,
    input  logic [2:0]                  access,
    input  logic [DATA_W-1:0]           bus_rdata,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           rdata,
    output logic [DATA_W-1:0]           bus_wdata
);
    localparam int NBYTES = DATA_W / 8;
    localparam int LANE_W = $clog2(NBYTES);

    logic [LANE_W-1:0] size_mask;
    logic [DATA_W-1:0] shifted;

    // size_mask has the low 'access' bits set: the byte offsets inside one access.
    always_comb begin
        size_mask = '0;
        for (int b = 0; b < LANE_W; b++) begin
            size_mask[b] = (access > 3'(b));
        end
    end

    assign shifted = bus_rdata >> {lane, 3'b000};

    always_comb begin
        rdata     = '0;
        bus_wdata = '0;
        for (int i = 0; i < NBYTES; i++) begin
            // keep only bytes that belong to the access, drop the rest
            if ((LANE_W'(i) & ~size_mask) == '0) begin
                rdata[8*i +: 8] = shifted[8*i +: 8];
            end
            // byte i of the bus takes byte (i mod access size) of the write value
            bus_wdata[8*i +: 8] = wdata[{LANE_W'(i) & size_mask, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/sba_ahb_master.sv
// Debug-module system bus access master on AHB: single transfers triggered by sbdata/sbaddress strobes.
// Latency: trigger -> REQ -> ADDR (after HGRANT) -> DATA (after HREADY) -> IDLE; result pulses one cycle later.
// Backpressure: HGRANT/HREADY stall the FSM; triggers while busy only flag sbbusyerror; timeout aborts.
// Ports: sys_clk/sys_rst, ahb (master modport), DM-side sb* strobes, mode bits, results and sticky errors.
module sba_ahb_master
    import dbg_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    sba_ahb_master_if.master    ahb,
    input  logic [ADDR_W-1:0]   sbaddress,
    input  logic                sbaddress_update,
    input  logic [DATA_W-1:0]   sbdata,
    input  logic                sbdata_wr,
    input  logic                sbdata_rd,
    input  logic                sbreadonaddr,
    input  logic                sbreadondata,
    input  logic                sbautoincrement,
    input  logic [2:0]          sbaccess,
    output logic [DATA_W-1:0]   sb_rdata,
    output logic                sb_rdata_valid,
    output logic [ADDR_W-1:0]   sb_addr_out,
    output logic                sb_addr_out_valid,
    output logic                sbbusy,
    output logic [2:0]          sberror,
    input  logic [2:0]          sberror_w1,
    output logic                sbbusyerror,
    input  logic                sbbusyerror_w1
);
    localparam int LANE_W = $clog2(DATA_W / 8);
    localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);

    sba_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_inc;
    logic [DATA_W-1:0] wdata_q, rd_aligned, bus_wdata;
    logic              write_q;
    logic [2:0]        access_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              trig_wr, trig_rd, trig_any, trig_open;
    logic              start_ok, busy_viol, size_bad, align_bad;
    logic [LANE_W-1:0] size_mask, eff_lane;
    logic              resp_err, done, timeout_fire;
    logic [2:0]        err_set;
    logic              busreq, hwrite;
    logic [1:0]        htrans;

    // Write has priority; both read triggers behave identically, so the
    // priority only decides the direction of the transfer.
    assign trig_wr   = sbdata_wr;
    assign trig_rd   = (sbaddress_update && sbreadonaddr) || (sbdata_rd && sbreadondata);
    assign trig_any  = trig_wr || trig_rd;
    // Any pending sticky error freezes the block until software clears it.
    assign trig_open = trig_any && (sberror == SBERR_NONE) && !sbbusyerror;

    // A new address strobed in the trigger cycle is the one that gets checked.
    assign eff_lane = sbaddress_update ? sbaddress[LANE_W-1:0] : addr_q[LANE_W-1:0];

    always_comb begin
        size_mask = '0;
        for (int b = 0; b < LANE_W; b++) begin
            size_mask[b] = (sbaccess > 3'(b));
        end
    end

    assign size_bad  = sbaccess > 3'(LANE_W);
    assign align_bad = |(eff_lane & size_mask);
    assign start_ok  = trig_open && (state_q == ST_IDLE) && !size_bad && !align_bad;
    assign busy_viol = trig_open && (state_q != ST_IDLE);

    assign resp_err = (state_q == ST_DATA) && (ahb.HRESP == HRESP_ERROR);
    assign done     = (state_q == ST_DATA) && ahb.HREADY && !resp_err;
    // A transfer completing in the very cycle the budget runs out is kept.
    assign timeout_fire = (state_q != ST_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1))
                          && !done && !resp_err;

    assign addr_inc = addr_q + (ADDR_W'(1) << access_q);

    always_comb begin
        err_set = SBERR_NONE;
        if (trig_open && (state_q == ST_IDLE)) begin
            if (size_bad)       err_set = SBERR_SIZE;
            else if (align_bad) err_set = SBERR_ALIGN;
        end
        if (resp_err)          err_set = SBERR_BUS;
        else if (timeout_fire) err_set = SBERR_TIMEOUT;
    end

    always_comb begin
        state_d = state_q;
        busreq  = 1'b0;
        htrans  = HTRANS_IDLE;
        hwrite  = 1'b0;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_REQ;
            ST_REQ: begin
                busreq = 1'b1;
                if (ahb.HGRANT) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                htrans = HTRANS_NONSEQ;
                hwrite = write_q;
                if (ahb.HREADY) state_d = ST_ADDR == ST_ADDR ? ST_DATA : ST_DATA;
            end
            ST_DATA: if (ahb.HREADY || resp_err) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (timeout_fire) state_d = ST_IDLE;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q           <= ST_IDLE;
            addr_q            <= '0;
            wdata_q           <= '0;
            write_q           <= 1'b0;
            access_q          <= '0;
            cnt_q             <= '0;
            sberror           <= SBERR_NONE;
            sbbusyerror       <= 1'b0;
            sb_rdata          <= '0;
            sb_rdata_valid    <= 1'b0;
            sb_addr_out       <= '0;
            sb_addr_out_valid <= 1'b0;
        end else begin
            state_q           <= state_d;
            sb_rdata_valid    <= 1'b0;
            sb_addr_out_valid <= 1'b0;
            // set wins over a simultaneous write-1-to-clear
            sberror     <= (sberror & ~sberror_w1) | err_set;
            sbbusyerror <= (sbbusyerror & ~sbbusyerror_w1) | busy_viol;
            // Registers are only reloaded while idle so a strobe cannot
            // disturb the address or data of a transfer in flight.
            if (state_q == ST_IDLE) begin
                if (sbaddress_update) addr_q  <= sbaddress;
                if (sbdata_wr)        wdata_q <= sbdata;
            end
            if (start_ok) begin
                write_q  <= trig_wr;
                access_q <= sbaccess;
                cnt_q    <= '0;
            end else if (state_q != ST_IDLE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (done) begin
                if (!write_q) begin
                    sb_rdata       <= rd_aligned;
                    sb_rdata_valid <= 1'b1;
                end
                if (sbautoincrement) begin
                    addr_q            <= addr_inc;
                    sb_addr_out       <= addr_inc;
                    sb_addr_out_valid <= 1'b1;
                end
            end
        end
    end

    sba_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .lane      (addr_q[LANE_W-1:0]),
        .access    (access_q),
        .bus_rdata (ahb.HRDATA),
        .wdata     (wdata_q),
        .rdata     (rd_aligned),
        .bus_wdata (bus_wdata)
    );

    assign sbbusy      = (state_q != ST_IDLE);
    assign ahb.HBUSREQ = busreq;
    assign ahb.HTRANS  = htrans;
    assign ahb.HWRITE  = hwrite;
    assign ahb.HADDR   = addr_q;
    assign ahb.HSIZE   = access_q;
    assign ahb.HWDATA  = bus_wdata;
    assign ahb.HBURST  = HBURST_SINGLE;
    assign ahb.HPROT   = HPROT_DATA;

endmodule

// File: tb/tb_sba_ahb_master.sv
// Directed bench: a 32-bit and a 64-bit instance share the DM-side stimulus
// and bus handshake; each scenario starts from reset. Both use a 16-cycle timeout.
module tb_sba_ahb_master;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [31:0] sbaddress;
    logic        sbaddress_update;
    logic [63:0] sbdata;
    logic        sbdata_wr, sbdata_rd;
    logic        sbreadonaddr, sbreadondata, sbautoincrement;
    logic [2:0]  sbaccess;
    logic [2:0]  sberror_w1;
    logic        sbbusyerror_w1;

    logic [31:0] rd32, ao32;
    logic        rdv32, aov32, busy32, berr32;
    logic [2:0]  err32;
    logic [63:0] rd64;
    logic [31:0] ao64;
    logic        rdv64, aov64, busy64, berr64;
    logic [2:0]  err64;

    int checks = 0;
    int errors = 0;
    int nonseq_cnt = 0, busreq_cnt = 0, busy_cnt = 0, aov_cnt = 0, rdv_cnt = 0;
    logic [31:0] last_haddr = '0;
    logic        last_hwrite = 1'b0;
    logic [2:0]  last_hsize = '0;

    sba_ahb_master_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
    sba_ahb_master_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

    always #5 clk = ~clk;

    sba_ahb_master #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(16)) dut32 (
        .sys_clk(clk), .sys_rst(sys_rst), .ahb(bus32.master),
        .sbaddress(sbaddress), .sbaddress_update(sbaddress_update),
        .sbdata(sbdata[31:0]), .sbdata_wr(sbdata_wr), .sbdata_rd(sbdata_rd),
        .sbreadonaddr(sbreadonaddr), .sbreadondata(sbreadondata),
        .sbautoincrement(sbautoincrement), .sbaccess(sbaccess),
        .sb_rdata(rd32), .sb_rdata_valid(rdv32),
        .sb_addr_out(ao32), .sb_addr_out_valid(aov32),
        .sbbusy(busy32), .sberror(err32), .sberror_w1(sberror_w1),
        .sbbusyerror(berr32), .sbbusyerror_w1(sbbusyerror_w1)
    );

    sba_ahb_master #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYC(16)) dut64 (
        .sys_clk(clk), .sys_rst(sys_rst), .ahb(bus64.master),
        .sbaddress(sbaddress), .sbaddress_update(sbaddress_update),
        .sbdata(sbdata), .sbdata_wr(sbdata_wr), .sbdata_rd(sbdata_rd),
        .sbreadonaddr(sbreadonaddr), .sbreadondata(sbreadondata),
        .sbautoincrement(sbautoincrement), .sbaccess(sbaccess),
        .sb_rdata(rd64), .sb_rdata_valid(rdv64),
        .sb_addr_out(ao64), .sb_addr_out_valid(aov64),
        .sbbusy(busy64), .sberror(err64), .sberror_w1(sberror_w1),
        .sbbusyerror(berr64), .sbbusyerror_w1(sbbusyerror_w1)
    );

    // Bus activity of the 32-bit instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus32.HTRANS == 2'b10) begin
            nonseq_cnt++;
            last_haddr  = bus32.HADDR;
            last_hwrite = bus32.HWRITE;
            last_hsize  = bus32.HSIZE;
        end
        if (bus32.HBUSREQ) busreq_cnt++;
        if (busy32)        busy_cnt++;
        if (aov32)         aov_cnt++;
        if (rdv32)         rdv_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_bus(input logic g, input logic r, input logic [1:0] resp);
        bus32.HGRANT = g; bus32.HREADY = r; bus32.HRESP = resp;
        bus64.HGRANT = g; bus64.HREADY = r; bus64.HRESP = resp;
    endtask

    task automatic clr_inputs();
        sbaddress = '0; sbaddress_update = 1'b0; sbdata = '0;
        sbdata_wr = 1'b0; sbdata_rd = 1'b0;
        sbreadonaddr = 1'b0; sbreadondata = 1'b0; sbautoincrement = 1'b0;
        sbaccess = 3'd2; sberror_w1 = '0; sbbusyerror_w1 = 1'b0;
    endtask

    task automatic do_reset();
        clr_inputs();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
        nonseq_cnt = 0; busreq_cnt = 0; busy_cnt = 0; aov_cnt = 0; rdv_cnt = 0;
    endtask

    initial begin
        clr_inputs();
        set_bus(1'b0, 1'b1, 2'b00);
        bus32.HRDATA = '0;
        bus64.HRDATA = '0;

        // ---- reset values ----
        sys_rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy32, 0);
        chk("rst_hbusreq", bus32.HBUSREQ, 0);
        chk("rst_htrans", bus32.HTRANS, 0);
        chk("rst_hwrite", bus32.HWRITE, 0);
        chk("rst_sberror", err32, 0);
        chk("rst_busyerr", berr32, 0);
        chk("rst_rdv", rdv32, 0);
        chk("rst_aov", aov32, 0);
        chk("rst_haddr", bus32.HADDR, 0);
        chk("rst_hwdata", bus64.HWDATA, 0);
        chk("rst_rdata", rd32, 0);
        chk("rst_hburst", bus32.HBURST, 3'b000);
        chk("rst_hprot", bus32.HPROT, 4'b0011);

        // ---- 32-bit word write at 0x100 ----
        do_reset();
        set_bus(1'b1, 1'b1, 2'b00);
        sbaccess = 3'd2; sbaddress = 32'h100; sbaddress_update = 1'b1;
        tick();
        sbaddress_update = 1'b0;
        chk("wr_no_trig_on_addr", busy32, 0);
        sbdata = 64'hA5A5_0001; sbdata_wr = 1'b1;
        tick();
        sbdata_wr = 1'b0;
        chk("wr_req_busy", busy32, 1);
        chk("wr_req_hbusreq", bus32.HBUSREQ, 1);
        chk("wr_req_htrans", bus32.HTRANS, 2'b00);
        tick();
        chk("wr_addr_htrans", bus32.HTRANS, 2'b10);
        chk("wr_addr_haddr", bus32.HADDR, 32'h100);
        chk("wr_addr_hsize", bus32.HSIZE, 3'd2);
        chk("wr_addr_hwrite", bus32.HWRITE, 1);
        tick();
        chk("wr_data_htrans", bus32.HTRANS, 2'b00);
        chk("wr_data_hwdata", bus32.HWDATA, 32'hA5A5_0001);
        chk("wr_data_hwdata64", bus64.HWDATA, 64'hA5A5_0001_A5A5_0001);
        tick();
        chk("wr_done_busy", busy32, 0);
        tick();
        chk("wr_busy_cycles", busy_cnt, 3);
        chk("wr_nonseq_count", nonseq_cnt, 1);
        chk("wr_no_rdv", rdv_cnt, 0);

        // ---- read-on-address with autoincrement, 64-bit lanes ----
        do_reset();
        set_bus(1'b1, 1'b1, 2'b00);
        bus64.HRDATA = 64'h1122_3344_5566_7788;
        bus32.HRDATA = 32'hDEAD_BEEF;
        sbaccess = 3'd2; sbautoincrement = 1'b1; sbreadonaddr = 1'b1;
        sbaddress = 32'h104; sbaddress_update = 1'b1;
        tick();
        sbaddress_update = 1'b0;
        tick();
        chk("ai_haddr64", bus64.HADDR, 32'h104);
        tick();
        tick();
        chk("ai_rdv64", rdv64, 1);
        chk("ai_rdata64", rd64, 64'h1122_3344);
        chk("ai_aov64", aov64, 1);
        chk("ai_addr_out64", ao64, 32'h108);
        chk("ai_rdata32", rd32, 32'hDEAD_BEEF);
        tick();
        chk("ai_rdv64_pulse", rdv64, 0);
        chk("ai_aov64_pulse", aov64, 0);
        // read-on-data from the incremented address
        sbreadondata = 1'b1; sbdata_rd = 1'b1;
        tick();
        sbdata_rd = 1'b0;
        tick();
        chk("rod_haddr64", bus64.HADDR, 32'h108);
        tick();
        tick();
        chk("rod_rdata64", rd64, 64'h5566_7788);
        chk("rod_addr_out64", ao64, 32'h10C);
        // byte read at lane 3
        sbreadondata = 1'b0; sbaccess = 3'd0;
        sbaddress = 32'h103; sbaddress_update = 1'b1;
        tick();
        sbaddress_update = 1'b0;
        tick();
        tick();
        tick();
        chk("byte_rdata32", rd32, 32'h0000_00DE);
        chk("byte_rdata64", rd64, 64'h55);
        chk("byte_addr_out32", ao32, 32'h104);

        // ---- priority: write beats readonaddr, address taken same cycle ----
        do_reset();
        set_bus(1'b1, 1'b1, 2'b00);
        sbaccess = 3'd0; sbreadonaddr = 1'b1;
        sbaddress = 32'h201; sbaddress_update = 1'b1;
        sbdata = 64'hC3; sbdata_wr = 1'b1;
        tick();
        sbaddress_update = 1'b0; sbdata_wr = 1'b0;
        tick();
        tick();
        chk("prio_hwdata32", bus32.HWDATA, 32'hC3C3_C3C3);
        chk("prio_hwdata64", bus64.HWDATA, 64'hC3C3_C3C3_C3C3_C3C3);
        tick();
        chk("prio_hwrite", last_hwrite, 1);
        chk("prio_haddr", last_haddr, 32'h201);
        chk("prio_hsize", last_hsize, 3'd0);
        chk("prio_no_rdv", rdv_cnt, 0);

        // ---- misaligned halfword ----
        do_reset();
        set_bus(1'b1, 1'b1, 2'b00);
        sbaccess = 3'd1; sbreadonaddr = 1'b1;
        sbaddress = 32'h3; sbaddress_update = 1'b1;
        tick();
        sbaddress_update = 1'b0;
        tick();
        tick();
        tick();
        chk("align_sberror", err32, 3'd3);
        chk("align_no_busreq", busreq_cnt, 0);
        chk("align_no_nonseq", nonseq_cnt, 0);

        // ---- unsupported size is reported ahead of misalignment ----
        do_reset();
        set_bus(1'b1, 1'b1, 2'b00);
        sbaccess = 3'd3; sbreadonaddr = 1'b1;
        sbaddress = 32'h1; sbaddress_update = 1'b1;
        tick();
        sbaddress_update = 1'b0;
        tick();
        chk("size_sberror", err32, 3'd4);
        chk("size_no_busreq", busreq_cnt, 0);
        sberror_w1 = 3'b100;
        tick();
        sberror_w1 = 3'b000;
        chk("size_w1_clear", err32, 3'd0);

        // ---- busy violation, set wins over clear, then ignored trigger ----
        do_reset();
        set_bus(1'b1, 1'b1, 2'b00);
        sbaccess = 3'd2; sbaddress = 32'h100; sbaddress_update = 1'b1;
        tick();
        sbaddress_update = 1'b0;
        sbdata = 64'h1234; sbdata_wr = 1'b1;
        tick();
        sbdata_wr = 1'b0;
        tick();
        tick();
        chk("bv_in_data", bus32.HTRANS, 2'b00);
        sbdata_wr = 1'b1; sbbusyerror_w1 = 1'b1;
        tick();
        sbdata_wr = 1'b0; sbbusyerror_w1 = 1'b0;
        chk("bv_busyerror", berr32, 1);
        chk("bv_sberror", err32, 0);
        sbdata_wr = 1'b1;
        tick();
        sbdata_wr = 1'b0;
        chk("bv_ignored_busy", busy32, 0);
        tick();
        chk("bv_one_nonseq", nonseq_cnt, 1);
        sbbusyerror_w1 = 1'b1;
        tick();
        sbbusyerror_w1 = 1'b0;
        chk("bv_cleared", berr32, 0);

        // ---- bus error in DATA ----
        do_reset();
        set_bus(1'b1, 1'b1, 2'b00);
        sbaccess = 3'd2; sbautoincrement = 1'b1; sbreadondata = 1'b1;
        sbdata_rd = 1'b1;
        tick();
        sbdata_rd = 1'b0;
        tick();
        tick();
        set_bus(1'b1, 1'b0, 2'b01);
        sberror_w1 = 3'b010;
        tick();
        set_bus(1'b1, 1'b1, 2'b00);
        sberror_w1 = 3'b000;
        chk("berr_sberror", err32, 3'd2);
        chk("berr_idle", busy32, 0);
        tick();
        tick();
        chk("berr_no_aov", aov_cnt, 0);
        chk("berr_no_rdv", rdv_cnt, 0);
        sberror_w1 = 3'b010;
        tick();
        sberror_w1 = 3'b000;
        chk("berr_w1_clear", err32, 3'd0);

        // ---- timeout with grant withheld ----
        do_reset();
        set_bus(1'b0, 1'b1, 2'b00);
        sbaccess = 3'd2; sbdata_wr = 1'b1;
        tick();
        sbdata_wr = 1'b0;
        chk("to_busreq", bus32.HBUSREQ, 1);
        repeat (15) tick();
        chk("to_not_yet", err32, 3'd0);
        chk("to_still_req", bus32.HBUSREQ, 1);
        tick();
        chk("to_sberror", err32, 3'd1);
        chk("to_busreq_drop", bus32.HBUSREQ, 0);
        chk("to_busy_drop", busy32, 0);
        chk("to_busy_cycles", busy_cnt, 16);

        // ---- reset in the middle of a read ----
        do_reset();
        set_bus(1'b1, 1'b1, 2'b00);
        sbaccess = 3'd2; sbreadonaddr = 1'b1;
        sbaddress = 32'h40; sbaddress_update = 1'b1;
        tick();
        sbaddress_update = 1'b0;
        tick();
        tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("mid_rst_busy", busy32, 0);
        chk("mid_rst_rdv", rdv32, 0);
        tick();
        chk("mid_rst_no_pulse", rdv_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
